// File: rtl/gf16_pkg.sv
// Shared GF(2^4) definitions: field polynomial, element type, FSM state set.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package gf16_pkg;

    // P(x) = x^4 + x^3 + 1
    localparam logic [4:0] GF16_POLY = 5'b11001;

    typedef logic [3:0] gf16_t;

    localparam gf16_t GF16_ONE = 4'h1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } gf16_state_e;

    // Multiply an element by x and reduce: x^4 folds back to x^3 + 1.
    function automatic gf16_t gf16_xtime(input gf16_t v);
        gf16_t sh;
        sh = {v[2:0], 1'b0};
        if (v[3]) begin
            sh = sh ^ GF16_POLY[3:0];
        end
        return sh;
    endfunction

endpackage

// File: rtl/gf16_div_if.sv
// Operand/result handshake bundle for the GF(2^4) divider.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready for operands, out_valid/out_ready for results.
// Signals: in_valid, in_ready, a, b (operand side); out_valid, out_ready, q,
// div_by_zero (result side). master = producer/consumer, slave = divider.
interface gf16_div_if;
    import gf16_pkg::*;

    logic  in_valid;
    logic  in_ready;
    gf16_t a;
    gf16_t b;
    logic  out_valid;
    logic  out_ready;
    gf16_t q;
    logic  div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, div_by_zero
    );

endinterface

// File: rtl/gf16_mul.sv
// Combinational GF(2^4) multiplier, reduction by GF16_POLY.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: x, y in (4 bits each); p out (4 bits) = x * y mod P(x).
module gf16_mul
    import gf16_pkg::*;
(
    input  gf16_t x,
    input  gf16_t y,
    output gf16_t p
);

    gf16_t acc;
    gf16_t sh;

    // Shift-and-add with reduction folded into every shift, so the
    // accumulator never exceeds 4 bits.
    always_comb begin
        acc = '0;
        sh  = x;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                acc = acc ^ sh;
            end
            sh = gf16_xtime(sh);
        end
    end

    assign p = acc;

endmodule

// File: rtl/gf16_div.sv
// Sequential GF(2^4) divider: q = a * b^14 = a / b, one operation in flight.
// Latency: out_valid rises 4 cycles after the operand accept edge; II = 6.
// Backpressure: holds the result in DONE while out_ready is low; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low); bus (gf16_div_if.slave) carrying
// in_valid/in_ready/a/b and out_valid/out_ready/q/div_by_zero.
module gf16_div
    import gf16_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    gf16_div_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ITER  = 2'(ITER);
    localparam logic [1:0] ST_FINAL = 2'(FINAL);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    logic [1:0] state;
    logic [1:0] cnt;
    gf16_t      a_r;
    gf16_t      t;
    gf16_t      r;
    logic       dz;
    gf16_t      q_r;
    logic       dz_out;
    logic       out_vld;

    gf16_t      t_sq;
    gf16_t      r_next;
    gf16_t      prod;

    // t walks B^2, B^4, B^8; r accumulates their product, reaching B^14.
    gf16_mul u_sq  (.x(t),   .y(t),    .p(t_sq));
    gf16_mul u_acc (.x(r),   .y(t_sq), .p(r_next));
    gf16_mul u_fin (.x(a_r), .y(r),    .p(prod));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_r     <= '0;
            t       <= '0;
            r       <= '0;
            dz      <= 1'b0;
            q_r     <= '0;
            dz_out  <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        t     <= bus.b;
                        r     <= GF16_ONE;
                        cnt   <= '0;
                        dz    <= (bus.b == '0);
                        state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    t   <= t_sq;
                    r   <= r_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd2) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    // B=0 drives r to 0 anyway; the explicit zero keeps q
                    // defined independently of that property.
                    q_r     <= dz ? '0 : prod;
                    dz_out  <= dz;
                    out_vld <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_vld && bus.out_ready) begin
                        out_vld <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready is a pure state decode, so the consuming edge cannot also
    // accept: new operands are taken no earlier than the following edge.
    assign bus.in_ready    = (state == ST_IDLE);
    assign bus.out_valid   = out_vld;
    assign bus.q           = q_r;
    assign bus.div_by_zero = dz_out;

endmodule

// File: tb/tb_gf16_div.sv
module tb_gf16_div;
    import gf16_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gf16_div_if bus ();

    gf16_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int cyc       = 0;
    int last_acc  = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: schoolbook polynomial product, then long division by P(x).
    function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) p = p ^ (8'(x) << i);
        end
        for (int k = 7; k >= 4; k--) begin
            if (p[k]) p = p ^ (8'h19 << (k - 4));
        end
        return p[3:0];
    endfunction

    // Reference quotient: find b's inverse by search, then multiply.
    function automatic logic [3:0] ref_div(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] inv;
        inv = 4'h0;
        if (y == 4'h0) return 4'h0;
        for (int v = 1; v < 16; v++) begin
            if (ref_mul(4'(v), y) == 4'h1) inv = 4'(v);
        end
        return ref_mul(x, inv);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the divider idle. Returns at the negedge where
    // out_valid is first seen; if out_ready is high it also lets the result be
    // consumed and returns one negedge later (divider idle again).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_q, input logic exp_dz,
                          input string tag, input bit check_ii);
        int lat;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        if (check_ii && last_acc >= 0)
            check({tag, ".ii"}, 32'(cyc - last_acc), 32'd6);
        last_acc     = cyc;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 4'($urandom);
        bus.b        = 4'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat - 1), 32'd4);
        check({tag, ".q"}, 32'(bus.q), 32'(exp_q));
        check({tag, ".dz"}, 32'(bus.div_by_zero), 32'(exp_dz));
        if (bus.out_ready) begin
            @(negedge clk);
            check({tag, ".post_out_valid"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [3:0] ra, rb, held_q;
        int stall;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 4'h0;
        bus.b         = 4'h0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.q", 32'(bus.q), 32'd0);
        check("rst.dz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed points with hand-derived quotients.
        run_op(4'h1, 4'h2, 4'hC, 1'b0, "d_1_2", 1'b0);
        run_op(4'h9, 4'h3, 4'h7, 1'b0, "d_9_3", 1'b0);
        run_op(4'hF, 4'h1, 4'hF, 1'b0, "d_F_1", 1'b0);
        run_op(4'h0, 4'h5, 4'h0, 1'b0, "d_0_5", 1'b0);
        run_op(4'h7, 4'h0, 4'h0, 1'b1, "d_7_0", 1'b0);

        // Backpressure: result held, new operands ignored while stalled.
        bus.out_ready = 1'b0;
        run_op(4'h9, 4'h3, 4'h7, 1'b0, "stall", 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 4'($urandom);
            bus.b        = 4'($urandom_range(1, 15));
            @(negedge clk);
            check("stall.out_valid", 32'(bus.out_valid), 32'd1);
            check("stall.q", 32'(bus.q), 32'h7);
            check("stall.in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release.in_ready", 32'(bus.in_ready), 32'd1);
        check("release.out_valid", 32'(bus.out_valid), 32'd0);
        check("release.q", 32'(bus.q), 32'h7);

        // Reset in the middle of ITER aborts immediately (q was 7 before).
        bus.a        = 4'h1;
        bus.b        = 4'h2;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.q", 32'(bus.q), 32'd0);
        check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst.dz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'h1, 4'h2, 4'hC, 1'b0, "after_rst", 1'b0);

        // Random operands with random consumer stalls.
        for (int n = 0; n < 24; n++) begin
            ra    = 4'($urandom);
            rb    = 4'($urandom);
            stall = int'($urandom_range(0, 3));
            bus.out_ready = (stall == 0);
            run_op(ra, rb, ref_div(ra, rb), (rb == 4'h0), $sformatf("rnd%0d", n), 1'b0);
            if (stall != 0) begin
                held_q = ref_div(ra, rb);
                repeat (stall) @(negedge clk);
                check($sformatf("rnd%0d.hold_q", n), 32'(bus.q), 32'(held_q));
                check($sformatf("rnd%0d.hold_vld", n), 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b1;
                @(negedge clk);
                check($sformatf("rnd%0d.in_ready", n), 32'(bus.in_ready), 32'd1);
            end
        end

        // Exhaustive, back-to-back: quotient against the model, II exactly 6.
        bus.out_ready = 1'b1;
        last_acc      = -1;
        for (int ea = 0; ea < 16; ea++) begin
            for (int eb = 0; eb < 16; eb++) begin
                run_op(4'(ea), 4'(eb), ref_div(4'(ea), 4'(eb)), (eb == 0),
                       $sformatf("ex_%0h_%0h", ea, eb), 1'b1);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gf16_div.md
# gf16_div

Sequential GF(2^4) divider, the inverse operation to the team's GF(2^4) multiplier. Computes Q = A / B = A · B^-1 over GF(2^4) with field polynomial P(x) = x^4 + x^3 + 1. B^-1 = B^14 is formed by three square-and-accumulate iterations, followed by a final multiply by A. Operands are accepted and results delivered over valid/ready handshakes, one operation in flight at a time.

## Interface
- Parameters: none; field polynomial fixed in shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  divider idle, can accept operands
- a  in  4  dividend A, polynomial basis, bit i = coeff of x^i
- b  in  4  divisor B, same basis
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  4  quotient A/B
- div_by_zero  out  1  B was 0; q forced to 0

## Operation
- One clock. Reset is asynchronous, active-low.
- FSM states: IDLE, ITER, FINAL, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: latch a_r=a, t=b, r=4'h1, cnt=0, dz=(b==0); go ITER.
- ITER, per cycle: t ← t·t, r ← r·(t·t), cnt ← cnt+1. After the 3rd iteration (cnt==2 at the edge), go FINAL. After the 3 iterations, r = B^2·B^4·B^8 = B^14.
- FINAL: q ← dz ? 0 : a_r·r; div_by_zero ← dz; out_valid ← 1; go DONE.
- DONE: q, div_by_zero, and out_valid are held stable. When out_valid && out_ready: out_valid ← 0, go IDLE.
- B=0: the iterations still run (r ends at 0). The result is q=0 with div_by_zero=1. Latency is unchanged.
- A=0, B≠0: q=0, div_by_zero=0.
- All field arithmetic is carry-less and 4 bits wide. Products are reduced modulo P(x): x^4 ≡ x^3+1.
- in_valid outside IDLE is ignored; a and b are not sampled.
- Reset asserted in any state: abort immediately, return to IDLE, clear all outputs. No partial result is ever presented.

## Timing
- Reset values: in_ready=1, out_valid=0, q=4'h0, div_by_zero=0.
- in_ready is decoded from the state register (IDLE). out_valid, q, and div_by_zero are registered.
- Accept edge E0 is the edge where in_valid && in_ready. ITER occupies the cycles after E0, E0+1, and E0+2. FINAL is the cycle after E0+3. out_valid first rises after edge E0+4, a latency of 4 cycles.
- Result consumed at edge Ek: in_ready=1 from the next cycle. There is no same-cycle accept of new operands.
- Minimum initiation interval is 6 cycles.
- out_ready held low: the block stalls in DONE indefinitely with outputs constant.

## Structure
- Package gf16_pkg holds:
  - localparam GF16_POLY = 5'b11001;
  - typedef gf16_t (logic [3:0]);
  - state enum {IDLE, ITER, FINAL, DONE};
  - localparam GF16_ONE = 4'h1.
- Sub-module gf16_mul: combinational 4-bit GF(2^4) multiply with reduction by GF16_POLY.
  - Instantiated three times: square t, accumulate r, final a_r·r.
  - Alternatively one instance muxed across states; both are acceptable.
- Top: FSM, 2-bit iteration counter, and registers a_r, t, r, dz, q.

## Test plan
- a=4'h1, b=4'h2: q=4'hC, div_by_zero=0, out_valid exactly 4 cycles after accept. Internal r sequence is 4, F, C.
- a=4'h9, b=4'h3: q=4'h7. a=4'hF, b=4'h1: q=4'hF. a=4'h0, b=4'h5: q=4'h0, div_by_zero=0.
- a=4'h7, b=4'h0: q=4'h0, div_by_zero=1, same latency.
- Hold out_ready=0 for 3 cycles after out_valid. Toggle in_valid with new operands meanwhile. Required: q and out_valid stable, in_ready=0, new operands ignored. Release out_ready: in_ready=1 the next cycle.
- Assert rst_n=0 mid-ITER: out_valid=0, q=0, and in_ready=1 immediately. After release, a fresh a=4'h1, b=4'h2 yields 4'hC.
- Exhaustive: all 256 (a,b) pairs, back-to-back with out_ready=1. Check q·b==a for b≠0 against a software GF(16) model. Initiation interval must be exactly 6 cycles.
